// File: rtl/bus_source_if.sv
// Command and bus signal bundle for bus_source_ctrl.
// master: the command sender / bus observer; slave: the controller itself.
interface bus_source_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned N_DST = 4,
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned SrcW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned DstW = (N_DST > 1) ? $clog2(N_DST) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [SrcW-1:0]       cmd_src;
  logic [DstW-1:0]       cmd_dst;
  logic [N_SRC*16-1:0]   src_data;
  logic [15:0]           bus;
  logic                  bus_drive;
  logic [N_DST-1:0]      load;
  logic                  xfer_done;
  logic                  busy;
  logic [CntW-1:0]       fifo_count;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, src_data,
    input  cmd_ready, bus, bus_drive, load, xfer_done, busy, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, src_data,
    output cmd_ready, bus, bus_drive, load, xfer_done, busy, fifo_count
  );
endinterface

// File: rtl/bus_source_ctrl.sv
// Internal bus write-side controller: queues {src, dst} transfer commands, drives the
// selected source word onto the bus for HOLD settle cycles, then pulses the one-hot load
// line of the destination for one cycle. Back-to-back transfers have no idle gap.
module bus_source_ctrl #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned N_DST = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 1
) (
  input logic         clk,
  input logic         rst_n,
  bus_source_if.slave bus_if
);
  localparam int unsigned SrcW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned DstW = (N_DST > 1) ? $clog2(N_DST) : 1;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned HW   = $clog2(HOLD + 1);

  localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);
  localparam logic [HW-1:0] HoldInit = HW'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StLoad} state_e;

  // Command FIFO
  logic [SrcW-1:0] fifo_src_q [DEPTH];
  logic [DstW-1:0] fifo_dst_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;

  // Transfer FSM and registered outputs
  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [DstW-1:0] dst_q, dst_d;
  logic [15:0]     bus_q, bus_d;
  logic            drive_q, drive_d;
  logic [N_DST-1:0] load_q, load_d;
  logic            done_q, done_d;

  logic [SrcW-1:0]  head_src;
  logic [DstW-1:0]  head_dst;
  logic [15:0]      head_word;
  logic [N_DST-1:0] dst_onehot;

  assign full     = (count_q == FullCnt);
  assign empty    = (count_q == '0);
  assign push     = bus_if.cmd_valid && !full;
  assign head_src = fifo_src_q[rd_ptr_q];
  assign head_dst = fifo_dst_q[rd_ptr_q];

  // Source word of the FIFO head; unmatched (out-of-range) indices read as zero.
  always_comb begin
    head_word = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (head_src == SrcW'(i)) head_word = bus_if.src_data[16*i +: 16];
    end
  end

  // One-hot decode of the latched destination; out-of-range leaves all lines low.
  always_comb begin
    dst_onehot = '0;
    for (int i = 0; i < int'(N_DST); i++) begin
      dst_onehot[i] = (dst_q == DstW'(i));
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src_q[wr_ptr_q] <= bus_if.cmd_src;
      fifo_dst_q[wr_ptr_q] <= bus_if.cmd_dst;
    end
  end

  // FIFO control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Transfer sequencing: a pop happens from IDLE or from the LOAD cycle so transfers chain.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dst_d   = dst_q;
    bus_d   = bus_q;
    drive_d = drive_q;
    load_d  = '0;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle, StLoad: begin
        if (!empty) begin
          pop     = 1'b1;
          dst_d   = head_dst;
          bus_d   = head_word;
          drive_d = 1'b1;
          hold_d  = HoldInit;
          state_d = StSetup;
        end else begin
          bus_d   = '0;
          drive_d = 1'b0;
          state_d = StIdle;
        end
      end
      StSetup: begin
        if (hold_q == '0) begin
          load_d  = dst_onehot;
          done_d  = 1'b1;
          state_d = StLoad;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
        bus_d   = '0;
        drive_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // FSM state and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      dst_q   <= '0;
      bus_q   <= '0;
      drive_q <= 1'b0;
      load_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dst_q   <= dst_d;
      bus_q   <= bus_d;
      drive_q <= drive_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  assign bus_if.cmd_ready  = !full;
  assign bus_if.bus        = bus_q;
  assign bus_if.bus_drive  = drive_q;
  assign bus_if.load       = load_q;
  assign bus_if.xfer_done  = done_q;
  assign bus_if.busy       = (state_q != StIdle) || !empty;
  assign bus_if.fifo_count = count_q;
endmodule
